// File: rtl/ps2_key_rx.sv
// Host-side PS/2 keyboard receiver: synchronise, de-glitch, deframe and decode prefixes into a toggle-event word.
// Build option: PS2_KEY_RX_PARITY_EN rejects frames whose odd parity check fails.
module ps2_key_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT        = 8,
   parameter int TIMEOUT     = 4000,
   parameter int TW          = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_dat,
   output logic [10:0] ps2_key,
   output logic        frame_err,
   output logic        busy
);

   // state    | meaning
   // S_IDLE   | waiting for a start bit (data low on a filtered falling edge)
   // S_DATA   | shifting in 8 data bits, LSB first
   // S_PARITY | capturing the parity bit
   // S_STOP   | checking the stop bit, then accepting or discarding the byte
   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam int            FW        = $clog2(FILT + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILT - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   sclk;
   logic                   sdat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync <= '1;
         dat_sync <= '1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      end
   end

   assign sclk = clk_sync[SYNC_STAGES-1];
   assign sdat = dat_sync[SYNC_STAGES-1];

   logic [FW-1:0] filt_cnt;
   logic          filt_clk;
   logic          filt_prev;
   logic          fall;

   // The filtered clock only follows after FILT consecutive differing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_cnt  <= '0;
         filt_clk  <= 1'b1;
         filt_prev <= 1'b1;
      end else begin
         filt_prev <= filt_clk;
         if (sclk != filt_clk) begin
            if (filt_cnt == FILT_LAST) begin
               filt_clk <= sclk;
               filt_cnt <= '0;
            end else begin
               filt_cnt <= filt_cnt + 1'b1;
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   assign fall = filt_prev & ~filt_clk;

   state_t        state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic          ext;
   logic          brk;
   logic [TW-1:0] to_cnt;
   logic          timeout_hit;
   logic          par_odd;
   logic          par_ok;

   assign par_odd = ^{shreg, par_bit};
`ifdef PS2_KEY_RX_PARITY_EN
   assign par_ok = par_odd;
`else
   // Parity is still captured so the frame shape is checked, but it never blocks acceptance.
   assign par_ok = par_odd | 1'b1;
`endif

   assign timeout_hit = (state != S_IDLE) && !fall && (to_cnt == TO_LAST);
   assign busy        = (state != S_IDLE);

   function automatic logic is_ctrl(input logic [7:0] c);
      case (c)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ctrl = 1'b1;
         default:                                  is_ctrl = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         ext       <= 1'b0;
         brk       <= 1'b0;
         to_cnt    <= '0;
         ps2_key   <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;

         if (state == S_IDLE || fall) begin
            to_cnt <= '0;
         end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
         end

         if (timeout_hit) begin
            state     <= S_IDLE;
            frame_err <= 1'b1;
            ext       <= 1'b0;
            brk       <= 1'b0;
         end else if (fall) begin
            case (state)
               S_IDLE: begin
                  if (!sdat) begin
                     state   <= S_DATA;
                     bit_cnt <= '0;
                  end
               end
               S_DATA: begin
                  shreg   <= {sdat, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) begin
                     state <= S_PARITY;
                  end
               end
               S_PARITY: begin
                  par_bit <= sdat;
                  state   <= S_STOP;
               end
               S_STOP: begin
                  state <= S_IDLE;
                  if (!sdat || !par_ok) begin
                     frame_err <= 1'b1;
                     ext       <= 1'b0;
                     brk       <= 1'b0;
                  end else if (shreg == 8'hE0 || shreg == 8'hE1) begin
                     ext <= 1'b1;
                  end else if (shreg == 8'hF0) begin
                     brk <= 1'b1;
                  end else if (!is_ctrl(shreg)) begin
                     ps2_key <= {~ps2_key[10], ~brk, ext, shreg};
                     ext     <= 1'b0;
                     brk     <= 1'b0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
